ht_mem_arbiter: RTL and testbench

- Shares one MIG-style application command port between two hash-table requesters:
  - the lookup (read) channel, issuing bucket fetches keyed by hash;
  - the update (write-back) channel, issuing bucket write-backs after key compare or insert.
- Sits in front of the clock-crossing command/data FIFOs that feed the DRAM controller; all logic runs on clk156.
- Provides fair round-robin arbitration, independent command/write-data handshakes, and issue counters.

---
 rtl/ht_pkg.sv | 18 +
 rtl/ht_rr_arb2.sv | 56 +++++
 rtl/ht_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ht_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ht_pkg.sv
// Shared types and constants for the hash-table memory arbiter slice.
package ht_pkg;

  localparam logic [2:0] MIG_CMD_READ  = 3'b001;
  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    WR_XFER = 2'd2
  } state_e;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_e;

endpackage

// File: rtl/ht_rr_arb2.sv
// Two-way round-robin grant between lookup and write-back requesters,
// with an override that forces the write to win a contest.
module ht_rr_arb2
  import ht_pkg::*;
(
  input  logic clk156,
  input  logic rst,
  input  logic en,
  input  logic req_rd,
  input  logic req_wr,
  input  logic raw_wr_first,
  output logic gnt_rd,
  output logic gnt_wr
);

  req_e rr_last_q, rr_last_d;

  // Grant decision and round-robin pointer update
  always_comb begin
    gnt_rd    = 1'b0;
    gnt_wr    = 1'b0;
    rr_last_d = rr_last_q;
    if (en) begin
      if (req_rd && req_wr) begin
        if (raw_wr_first || (rr_last_q == REQ_RD)) begin
          gnt_wr = 1'b1;
        end else begin
          gnt_rd = 1'b1;
        end
      end else begin
        gnt_rd = req_rd;
        gnt_wr = req_wr;
      end
      // A grant is always a handshake, since ready mirrors the grant
      if (gnt_rd) begin
        rr_last_d = REQ_RD;
      end else if (gnt_wr) begin
        rr_last_d = REQ_WR;
      end else begin
        rr_last_d = rr_last_q;
      end
    end else begin
      rr_last_d = rr_last_q;
    end
  end

  // Round-robin pointer; WR after reset so the first contest goes to read
  always_ff @(posedge clk156) begin
    if (rst) begin
      rr_last_q <= REQ_WR;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/ht_mem_arbiter.sv
// Shares one MIG app command port between hash-table lookup and write-back.
// Define HT_ARB_RAW_ORDER_EN to let a same-bucket write beat a pending read.
module ht_mem_arbiter
  import ht_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 512,
  parameter int STRB_W = 64
) (
  input  logic              clk156,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [STRB_W-1:0] wr_req_mask,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [STRB_W-1:0] app_wdf_mask,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  output logic [31:0]       rd_issued_cnt,
  output logic [31:0]       wr_issued_cnt
);

  state_e              state_q, state_d;
  logic                app_en_q, app_en_d;
  logic [2:0]          app_cmd_q, app_cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wmask_q, wmask_d;
  logic                wren_q, wren_d;
  logic                cmd_done_q, cmd_done_d;
  logic                dat_done_q, dat_done_d;
  logic [31:0]         rd_issued_cnt_q, rd_issued_cnt_d;
  logic [31:0]         wr_issued_cnt_q, wr_issued_cnt_d;

  logic idle_s, gnt_rd_s, gnt_wr_s, raw_s;
  logic cmd_fire_s, dat_fire_s, cmd_done_s, dat_done_s;

`ifdef HT_ARB_RAW_ORDER_EN
  assign raw_s = rd_req_valid && wr_req_valid && (rd_req_addr == wr_req_addr);
`else
  assign raw_s = 1'b0;
`endif

  assign idle_s     = (state_q == IDLE);
  assign cmd_fire_s = app_en_q & app_rdy;
  assign dat_fire_s = wren_q & app_wdf_rdy;

  ht_rr_arb2 u_arb (
    .clk156       (clk156),
    .rst          (rst),
    .en           (idle_s),
    .req_rd       (rd_req_valid),
    .req_wr       (wr_req_valid),
    .raw_wr_first (raw_s),
    .gnt_rd       (gnt_rd_s),
    .gnt_wr       (gnt_wr_s)
  );

  assign rd_req_ready = gnt_rd_s;
  assign wr_req_ready = gnt_wr_s;

  // Transaction FSM: capture on grant, hold until the app port has taken it
  always_comb begin
    state_d         = state_q;
    app_en_d        = app_en_q;
    app_cmd_d       = app_cmd_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    wren_d          = wren_q;
    cmd_done_d      = cmd_done_q;
    dat_done_d      = dat_done_q;
    rd_issued_cnt_d = rd_issued_cnt_q;
    wr_issued_cnt_d = wr_issued_cnt_q;
    cmd_done_s      = cmd_done_q | cmd_fire_s;
    dat_done_s      = dat_done_q | dat_fire_s;
    case (state_q)
      IDLE: begin
        if (gnt_rd_s) begin
          addr_d    = rd_req_addr;
          app_cmd_d = MIG_CMD_READ;
          app_en_d  = 1'b1;
          state_d   = RD_CMD;
        end else if (gnt_wr_s) begin
          addr_d     = wr_req_addr;
          wdata_d    = wr_req_data;
          wmask_d    = wr_req_mask;
          app_cmd_d  = MIG_CMD_WRITE;
          app_en_d   = 1'b1;
          wren_d     = 1'b1;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          state_d    = WR_XFER;
        end else begin
          state_d = IDLE;
        end
      end
      RD_CMD: begin
        if (cmd_fire_s) begin
          app_en_d        = 1'b0;
          rd_issued_cnt_d = rd_issued_cnt_q + 32'd1;
          state_d         = IDLE;
        end else begin
          state_d = RD_CMD;
        end
      end
      WR_XFER: begin
        // Command and data channels retire independently, in any order
        app_en_d   = app_en_q & ~cmd_fire_s;
        wren_d     = wren_q & ~dat_fire_s;
        cmd_done_d = cmd_done_s;
        dat_done_d = dat_done_s;
        if (cmd_done_s && dat_done_s) begin
          wr_issued_cnt_d = wr_issued_cnt_q + 32'd1;
          cmd_done_d      = 1'b0;
          dat_done_d      = 1'b0;
          state_d         = IDLE;
        end else begin
          state_d = WR_XFER;
        end
      end
      default: begin
        app_en_d = 1'b0;
        wren_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State, captured request and counters; reset drops any in-flight command
  always_ff @(posedge clk156) begin
    if (rst) begin
      state_q         <= IDLE;
      app_en_q        <= 1'b0;
      app_cmd_q       <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      wren_q          <= 1'b0;
      cmd_done_q      <= 1'b0;
      dat_done_q      <= 1'b0;
      rd_issued_cnt_q <= 32'd0;
      wr_issued_cnt_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      app_en_q        <= app_en_d;
      app_cmd_q       <= app_cmd_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      wren_q          <= wren_d;
      cmd_done_q      <= cmd_done_d;
      dat_done_q      <= dat_done_d;
      rd_issued_cnt_q <= rd_issued_cnt_d;
      wr_issued_cnt_q <= wr_issued_cnt_d;
    end
  end

  assign app_en        = app_en_q;
  assign app_cmd       = app_cmd_q;
  assign app_addr      = addr_q;
  assign app_wdf_wren  = wren_q;
  assign app_wdf_end   = wren_q;
  assign app_wdf_data  = wdata_q;
  assign app_wdf_mask  = wmask_q;
  assign rd_issued_cnt = rd_issued_cnt_q;
  assign wr_issued_cnt = wr_issued_cnt_q;

endmodule

// File: tb/tb_ht_mem_arbiter.sv
// Directed self-checking bench for ht_mem_arbiter; inputs change and outputs
// are sampled around the falling edge of clk156.
module tb_ht_mem_arbiter;

  localparam int AW = 30;
  localparam int DW = 512;
  localparam int SW = 64;

  logic          clk156 = 1'b0;
  logic          rst;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic [SW-1:0] wr_req_mask;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy;
  logic          app_wdf_wren;
  logic [DW-1:0] app_wdf_data;
  logic [SW-1:0] app_wdf_mask;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [31:0]   rd_issued_cnt, wr_issued_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] wdat_pat;
  logic [SW-1:0] wmask_pat;
  int            grants;
  int            cycles;
  logic          exp_wr_first;

  always #5 clk156 = ~clk156;

  ht_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
    .clk156        (clk156),
    .rst           (rst),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .wr_req_mask   (wr_req_mask),
    .app_en        (app_en),
    .app_cmd       (app_cmd),
    .app_addr      (app_addr),
    .app_rdy       (app_rdy),
    .app_wdf_wren  (app_wdf_wren),
    .app_wdf_data  (app_wdf_data),
    .app_wdf_mask  (app_wdf_mask),
    .app_wdf_end   (app_wdf_end),
    .app_wdf_rdy   (app_wdf_rdy),
    .rd_issued_cnt (rd_issued_cnt),
    .wr_issued_cnt (wr_issued_cnt)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with rst low
  task automatic do_reset();
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk156);
    rst = 1'b0;
  endtask

  // Bound the whole run in case the design stops responding
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wdat_pat     = {8{64'hA5A5_0000_DEAD_BEEF}};
    wmask_pat    = 64'h0000_0000_0000_00FF;
    rst          = 1'b1;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    wr_req_valid = 1'b0;
    wr_req_addr  = '0;
    wr_req_data  = '0;
    wr_req_mask  = '0;
    app_rdy      = 1'b0;
    app_wdf_rdy  = 1'b0;
    repeat (3) @(negedge clk156);

    // Reset state
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_wdf_end", app_wdf_end, 1'b0);
    chk("rst_cmd", app_cmd, 3'b000);
    chk("rst_addr", app_addr, 30'h0);
    chk("rst_rd_cnt", rd_issued_cnt, 32'd0);
    chk("rst_wr_cnt", wr_issued_cnt, 32'd0);
    rst = 1'b0;

    // Single read, app_rdy already high
    rd_req_valid = 1'b1;
    rd_req_addr  = 30'h0000_1234;
    app_rdy      = 1'b1;
    #1;
    chk("rd1_ready", rd_req_ready, 1'b1);
    chk("rd1_wr_ready", wr_req_ready, 1'b0);
    @(negedge clk156);
    rd_req_valid = 1'b0;
    #1;
    chk("rd1_app_en", app_en, 1'b1);
    chk("rd1_cmd", app_cmd, 3'b001);
    chk("rd1_addr", app_addr, 30'h0000_1234);
    chk("rd1_ready_busy", rd_req_ready, 1'b0);
    @(negedge clk156);
    #1;
    chk("rd1_app_en_off", app_en, 1'b0);
    chk("rd1_cnt", rd_issued_cnt, 32'd1);

    // Single write: data taken at once, command stalled three cycles
    wr_req_valid = 1'b1;
    wr_req_addr  = 30'h0000_2000;
    wr_req_data  = wdat_pat;
    wr_req_mask  = wmask_pat;
    app_rdy      = 1'b0;
    app_wdf_rdy  = 1'b1;
    #1;
    chk("wr1_ready", wr_req_ready, 1'b1);
    chk("wr1_rd_ready", rd_req_ready, 1'b0);
    @(negedge clk156);
    wr_req_addr = 30'h3FFF_FFFF;
    wr_req_data = '0;
    wr_req_mask = '1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk156);
      app_rdy      = (i == 3);
      wr_req_valid = (i == 1);
      #1;
      chk("wr1_app_en", app_en, 1'b1);
      chk("wr1_cmd", app_cmd, 3'b000);
      chk("wr1_addr", app_addr, 30'h0000_2000);
      chk("wr1_data", app_wdf_data, wdat_pat);
      chk("wr1_mask", app_wdf_mask, wmask_pat);
      chk("wr1_wren", app_wdf_wren, (i == 0));
      chk("wr1_end", app_wdf_end, (i == 0));
      chk("wr1_no_accept", wr_req_ready, 1'b0);
    end
    @(negedge clk156);
    wr_req_valid = 1'b0;
    #1;
    chk("wr1_app_en_off", app_en, 1'b0);
    chk("wr1_wren_off", app_wdf_wren, 1'b0);
    chk("wr1_cnt", wr_issued_cnt, 32'd1);
    chk("wr1_rd_cnt_kept", rd_issued_cnt, 32'd1);

    // Both requesters always valid: strict alternation, R first after reset
    @(negedge clk156);
    do_reset();
    app_rdy      = 1'b1;
    app_wdf_rdy  = 1'b1;
    rd_req_addr  = 30'h0000_0100;
    wr_req_addr  = 30'h0000_0200;
    wr_req_data  = wdat_pat;
    rd_req_valid = 1'b1;
    wr_req_valid = 1'b1;
    grants = 0;
    cycles = 0;
    while (grants < 8 && cycles < 60) begin
      #1;
      if (rd_req_ready || wr_req_ready) begin
        chk("alt_grant_is_wr", wr_req_ready, (grants % 2 == 1));
        chk("alt_one_hot", rd_req_ready ^ wr_req_ready, 1'b1);
        grants++;
      end
      @(negedge clk156);
      cycles++;
    end
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    chk("alt_grants", grants, 8);
    chk("alt_spacing", cycles, 15);
    @(negedge clk156);
    #1;
    chk("alt_rd_cnt", rd_issued_cnt, 32'd4);
    chk("alt_wr_cnt", wr_issued_cnt, 32'd4);

    // Reset while a write command is stalled
    @(negedge clk156);
    wr_req_valid = 1'b1;
    wr_req_addr  = 30'h0000_0055;
    app_rdy      = 1'b0;
    app_wdf_rdy  = 1'b0;
    @(negedge clk156);
    wr_req_valid = 1'b0;
    #1;
    chk("mid_app_en_pre", app_en, 1'b1);
    rst = 1'b1;
    @(negedge clk156);
    rst = 1'b0;
    #1;
    chk("mid_app_en", app_en, 1'b0);
    chk("mid_wren", app_wdf_wren, 1'b0);
    chk("mid_rd_cnt", rd_issued_cnt, 32'd0);
    chk("mid_wr_cnt", wr_issued_cnt, 32'd0);
    rd_req_valid = 1'b1;
    wr_req_valid = 1'b1;
    rd_req_addr  = 30'h0000_0100;
    wr_req_addr  = 30'h0000_0200;
    app_rdy      = 1'b1;
    app_wdf_rdy  = 1'b1;
    #1;
    chk("mid_next_rd", rd_req_ready, 1'b1);
    chk("mid_next_wr", wr_req_ready, 1'b0);
    @(negedge clk156);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    @(negedge clk156);
    #1;
    chk("mid_next_rd_cnt", rd_issued_cnt, 32'd1);
    chk("mid_next_wr_cnt", wr_issued_cnt, 32'd0);

    // Same-bucket contest right after reset (rr_last = WR)
    @(negedge clk156);
    do_reset();
`ifdef HT_ARB_RAW_ORDER_EN
    exp_wr_first = 1'b1;
`else
    exp_wr_first = 1'b0;
`endif
    rd_req_addr  = 30'h0000_0040;
    wr_req_addr  = 30'h0000_0040;
    rd_req_valid = 1'b1;
    wr_req_valid = 1'b1;
    #1;
    chk("raw_first_wr", wr_req_ready, exp_wr_first);
    chk("raw_first_rd", rd_req_ready, !exp_wr_first);
    @(negedge clk156);
    if (exp_wr_first) wr_req_valid = 1'b0;
    else rd_req_valid = 1'b0;
    @(negedge clk156);
    #1;
    chk("raw_second_wr", wr_req_ready, !exp_wr_first);
    chk("raw_second_rd", rd_req_ready, exp_wr_first);
    @(negedge clk156);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    @(negedge clk156);
    #1;
    chk("raw_rd_cnt", rd_issued_cnt, 32'd1);
    chk("raw_wr_cnt", wr_issued_cnt, 32'd1);

    // Read counter wrap
    @(negedge clk156);
    force dut.rd_issued_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_issued_cnt_q;
    #1;
    chk("wrap_preload", rd_issued_cnt, 32'hFFFF_FFFF);
    rd_req_valid = 1'b1;
    rd_req_addr  = 30'h0000_0077;
    @(negedge clk156);
    rd_req_valid = 1'b0;
    @(negedge clk156);
    #1;
    chk("wrap_rd_cnt", rd_issued_cnt, 32'd0);
    chk("wrap_wr_cnt", wr_issued_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
